// File: rtl/pool_spike_encoder_pkg.sv
// Shared types and defaults for the pooled-pixel spike encoder.
// POOL_TIMESTEP_MARKER_EN adds the MARKER state used for end-of-timestep marker words.
package pool_spike_encoder_pkg;

    localparam int unsigned DEFAULT_COORD_BITS  = 8;
    localparam int unsigned DEFAULT_CHANNELS    = 4;
    localparam int unsigned DEFAULT_CH_IDX_BITS = (DEFAULT_CHANNELS > 1) ? $clog2(DEFAULT_CHANNELS) : 1;
    localparam int unsigned DEFAULT_COUNT_BITS  = 16;

    typedef struct packed {
        logic [DEFAULT_COORD_BITS-1:0]  x;
        logic [DEFAULT_COORD_BITS-1:0]  y;
        logic [DEFAULT_CH_IDX_BITS-1:0] ch;
    } pool_event_t;

`ifdef POOL_TIMESTEP_MARKER_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_MARKER = 2'd2
    } encoder_state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } encoder_state_t;
`endif

    // Channel index width, never below one bit.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_spike_encoder_if.sv
// Pixel-in / event-out handshake bundle of the pooled-pixel spike encoder.
interface pool_spike_encoder_if
    import pool_spike_encoder_pkg::*;
#(
    parameter int unsigned COORD_BITS = DEFAULT_COORD_BITS,
    parameter int unsigned CHANNELS   = DEFAULT_CHANNELS
) ();

    localparam int unsigned CH_IDX_BITS = idx_bits(CHANNELS);
    localparam int unsigned EVENT_WIDTH = 2 * COORD_BITS + CH_IDX_BITS;

    logic                   in_valid;
    logic                   in_ready;
    logic [COORD_BITS-1:0]  in_x;
    logic [COORD_BITS-1:0]  in_y;
    logic [CHANNELS-1:0]    in_spikes;
    logic                   in_last;
    logic [EVENT_WIDTH-1:0] out_event;
    logic                   out_write_en;
    logic                   out_fifo_full;

    modport master (
        output in_valid, in_x, in_y, in_spikes, in_last, out_fifo_full,
        input  in_ready, out_event, out_write_en
    );

    modport slave (
        input  in_valid, in_x, in_y, in_spikes, in_last, out_fifo_full,
        output in_ready, out_event, out_write_en
    );

endinterface

// File: rtl/lowest_set_bit_enc.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_bit_enc #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned IDX_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] i_vec,
    output logic [IDX_BITS-1:0] o_idx,
    output logic                o_any
);

    // Scan from the top so the lowest set bit is written last and wins.
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = IDX_BITS'(i);
        end
    end

endmodule

// File: rtl/pool_spike_encoder.sv
// Serialises each pooled pixel's spike vector into {x, y, ch} output FIFO events.
// POOL_TIMESTEP_MARKER_EN appends an all-ones coordinate marker word after each timestep.
module pool_spike_encoder
    import pool_spike_encoder_pkg::*;
#(
    parameter int unsigned COORD_BITS = DEFAULT_COORD_BITS,
    parameter int unsigned CHANNELS   = DEFAULT_CHANNELS,
    parameter int unsigned COUNT_BITS = DEFAULT_COUNT_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sys_reset,
    pool_spike_encoder_if.slave   bus,
    output logic                  busy,
    output logic [COUNT_BITS-1:0] ts_event_count,
    output logic                  ts_done
);

    localparam int unsigned CH_IDX_BITS = idx_bits(CHANNELS);

    encoder_state_t         r_state;
    logic [COORD_BITS-1:0]  r_x;
    logic [COORD_BITS-1:0]  r_y;
    logic [CHANNELS-1:0]    r_spikes;
    logic                   r_last;
    logic [COUNT_BITS-1:0]  r_run_cnt;
    logic [COUNT_BITS-1:0]  r_ts_count;
    logic                   r_ts_done;

    logic [CH_IDX_BITS-1:0] w_ch;
    logic                   w_any;
    logic                   w_accept;
    logic                   w_write_emit;
    logic                   w_final;
    logic [CHANNELS-1:0]    w_spikes_next;
    logic [COUNT_BITS-1:0]  w_cnt_inc;

    lowest_set_bit_enc #(
        .CHANNELS (CHANNELS),
        .IDX_BITS (CH_IDX_BITS)
    ) u_lsb (
        .i_vec (r_spikes),
        .o_idx (w_ch),
        .o_any (w_any)
    );

    assign w_accept      = bus.in_valid && (r_state == ST_IDLE);
    // A write is suppressed while the FIFO is full or a synchronous clear is discarding the pixel.
    assign w_write_emit  = (r_state == ST_EMIT) && w_any && !bus.out_fifo_full && !sys_reset;
    assign w_spikes_next = r_spikes & ~(CHANNELS'(1) << w_ch);
    assign w_final       = (w_spikes_next == '0);
    assign w_cnt_inc     = (r_run_cnt == '1) ? r_run_cnt : r_run_cnt + COUNT_BITS'(1);

`ifdef POOL_TIMESTEP_MARKER_EN
    logic w_write_marker;
    assign w_write_marker   = (r_state == ST_MARKER) && !bus.out_fifo_full && !sys_reset;
    assign bus.out_write_en = w_write_emit || w_write_marker;
    assign bus.out_event    = (r_state == ST_MARKER)
                            ? {{COORD_BITS{1'b1}}, {COORD_BITS{1'b1}}, {CH_IDX_BITS{1'b0}}}
                            : {r_x, r_y, w_ch};
`else
    assign bus.out_write_en = w_write_emit;
    assign bus.out_event    = {r_x, r_y, w_ch};
`endif

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign ts_event_count = r_ts_count;
    assign ts_done        = r_ts_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_spikes   <= '0;
            r_last     <= 1'b0;
            r_run_cnt  <= '0;
            r_ts_count <= '0;
            r_ts_done  <= 1'b0;
        end else if (sys_reset) begin
            r_state    <= ST_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_spikes   <= '0;
            r_last     <= 1'b0;
            r_run_cnt  <= '0;
            r_ts_count <= '0;
            r_ts_done  <= 1'b0;
        end else begin
            r_ts_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x      <= bus.in_x;
                        r_y      <= bus.in_y;
                        r_spikes <= bus.in_spikes;
                        r_last   <= bus.in_last;
                        if (|bus.in_spikes) begin
                            r_state <= ST_EMIT;
                        end else if (bus.in_last) begin
`ifdef POOL_TIMESTEP_MARKER_EN
                            r_state    <= ST_MARKER;
`else
                            r_ts_count <= r_run_cnt;
                            r_run_cnt  <= '0;
                            r_ts_done  <= 1'b1;
`endif
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_write_emit) begin
                        r_spikes  <= w_spikes_next;
                        r_run_cnt <= w_cnt_inc;
                        if (w_final) begin
                            r_state <= ST_IDLE;
                            if (r_last) begin
`ifdef POOL_TIMESTEP_MARKER_EN
                                r_state    <= ST_MARKER;
`else
                                r_ts_count <= w_cnt_inc;
                                r_run_cnt  <= '0;
                                r_ts_done  <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef POOL_TIMESTEP_MARKER_EN
                ST_MARKER: begin
                    // Marker word is not counted; the timestep closes on its write.
                    if (w_write_marker) begin
                        r_ts_count <= r_run_cnt;
                        r_run_cnt  <= '0;
                        r_ts_done  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_spike_encoder.sv
// Directed bench for pool_spike_encoder in its default build (marker feature disabled).
module tb_pool_spike_encoder;
    import pool_spike_encoder_pkg::*;

    localparam int unsigned CB   = DEFAULT_COORD_BITS;
    localparam int unsigned CH   = DEFAULT_CHANNELS;
    localparam int unsigned CNTB = DEFAULT_COUNT_BITS;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sys_reset = 1'b0;
    logic            busy;
    logic [CNTB-1:0] ts_event_count;
    logic            ts_done;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    pool_event_t wq[$];

    pool_spike_encoder_if #(.COORD_BITS(CB), .CHANNELS(CH)) bus ();

    pool_spike_encoder #(
        .COORD_BITS (CB),
        .CHANNELS   (CH),
        .COUNT_BITS (CNTB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sys_reset      (sys_reset),
        .bus            (bus),
        .busy           (busy),
        .ts_event_count (ts_event_count),
        .ts_done        (ts_done)
    );

    always #5 clk = ~clk;

    // Log every FIFO write and every ts_done pulse seen mid-cycle.
    always @(negedge clk) begin
        if (bus.out_write_en) wq.push_back(pool_event_t'(bus.out_event));
        if (ts_done) done_pulses++;
    end

    function automatic pool_event_t mk_ev(input int x, input int y, input int ch);
        pool_event_t e;
        e.x  = CB'(x);
        e.y  = CB'(y);
        e.ch = DEFAULT_CH_IDX_BITS'(ch);
        return e;
    endfunction

    task automatic send_pixel(input logic [CB-1:0] x, input logic [CB-1:0] y,
                              input logic [CH-1:0] s, input logic last);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_spikes = s;
        bus.in_last   = last;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_spikes = '0;
        bus.in_last   = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0;
        bus.in_spikes = '0; bus.in_last = 1'b0; bus.out_fifo_full = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_write_en !== 1'b0 || busy !== 1'b0 ||
            ts_done !== 1'b0 || ts_event_count !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b we=%b busy=%b done=%b cnt=%0d required 1 0 0 0 0",
                     bus.in_ready, bus.out_write_en, busy, ts_done, ts_event_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: ready=%b busy=%b required 1 0", bus.in_ready, busy);
        end
    endtask

    task automatic test_single_pixel();
        wq.delete();
        send_pixel(8'd3, 8'd5, 4'b1010, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_write_en !== 1'b1 || bus.out_event !== mk_ev(3, 5, 1) || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ev0: we=%b ev=%h ready=%b required 1 %h 0",
                     bus.out_write_en, bus.out_event, bus.in_ready, mk_ev(3, 5, 1));
        end
        @(negedge clk);
        checks++;
        if (bus.out_write_en !== 1'b1 || bus.out_event !== mk_ev(3, 5, 3) || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ev1: we=%b ev=%h ready=%b required 1 %h 0",
                     bus.out_write_en, bus.out_event, bus.in_ready, mk_ev(3, 5, 3));
        end
        @(negedge clk);
        checks++;
        if (bus.out_write_en !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_done: we=%b ready=%b required 0 1", bus.out_write_en, bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (wq.size() != 2) begin
            errors++;
            $display("FAIL single_count: writes=%0d required 2", wq.size());
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int stall_writes = 0;
        wq.delete();
        send_pixel(8'd1, 8'd2, 4'b1111, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_write_en !== 1'b1 || bus.out_event !== mk_ev(1, 2, 0)) begin
            errors++;
            $display("FAIL bp_first: we=%b ev=%h required 1 %h", bus.out_write_en, bus.out_event, mk_ev(1, 2, 0));
        end
        @(posedge clk); #1;
        bus.out_fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_write_en !== 1'b0 || busy !== 1'b1) stall_writes++;
        end
        checks++;
        if (stall_writes != 0) begin
            errors++;
            $display("FAIL bp_stall: bad_stall_cycles=%0d required 0", stall_writes);
        end
        @(posedge clk); #1;
        bus.out_fifo_full = 1'b0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if (wq.size() != 4) begin
            errors++;
            $display("FAIL bp_count: writes=%0d required 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wq[i] !== mk_ev(1, 2, i)) begin
                    errors++;
                    $display("FAIL bp_order%0d: ev=%h required %h", i, wq[i], mk_ev(1, 2, i));
                end
            end
        end
    endtask

    task automatic test_zero_vector();
        wq.delete();
        send_pixel(8'd7, 8'd7, 4'b0000, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_write_en !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 || ts_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_vec: we=%b ready=%b busy=%b done=%b required 0 1 0 0",
                     bus.out_write_en, bus.in_ready, busy, ts_done);
        end
        @(posedge clk); #1;
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL zero_vec_writes: writes=%0d required 0", wq.size());
        end
    endtask

    task automatic test_timestep();
        int wr = 0;
        @(negedge clk); sys_reset = 1'b1;
        @(negedge clk); sys_reset = 1'b0;
        wq.delete();
        done_pulses = 0;
        send_pixel(8'd1, 8'd1, 4'b0011, 1'b0);
        send_pixel(8'd2, 8'd2, 4'b0000, 1'b0);
        send_pixel(8'd3, 8'd3, 4'b0111, 1'b1);
        repeat (3) begin
            @(negedge clk);
            if (bus.out_write_en === 1'b1 && ts_done === 1'b0) wr++;
        end
        checks++;
        if (wr != 3) begin
            errors++;
            $display("FAIL ts_last_writes: write_cycles=%0d required 3", wr);
        end
        @(negedge clk);
        checks++;
        if (ts_done !== 1'b1 || ts_event_count !== CNTB'(5) || bus.out_write_en !== 1'b0) begin
            errors++;
            $display("FAIL ts_done_pulse: done=%b cnt=%0d we=%b required 1 5 0",
                     ts_done, ts_event_count, bus.out_write_en);
        end
        @(negedge clk);
        checks++;
        if (ts_done !== 1'b0 || ts_event_count !== CNTB'(5)) begin
            errors++;
            $display("FAIL ts_done_width: done=%b cnt=%0d required 0 5", ts_done, ts_event_count);
        end
        @(posedge clk); #1;
        checks++;
        if (done_pulses != 1 || wq.size() != 5) begin
            errors++;
            $display("FAIL ts_totals: pulses=%0d writes=%0d required 1 5", done_pulses, wq.size());
        end
        send_pixel(8'd4, 8'd4, 4'b0001, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ts_done !== 1'b1 || ts_event_count !== CNTB'(1)) begin
            errors++;
            $display("FAIL ts_restart: done=%b cnt=%0d required 1 1", ts_done, ts_event_count);
        end
        send_pixel(8'd5, 8'd5, 4'b0000, 1'b1);
        @(negedge clk);
        checks++;
        if (ts_done !== 1'b1 || ts_event_count !== CNTB'(0) || bus.out_write_en !== 1'b0) begin
            errors++;
            $display("FAIL ts_empty_last: done=%b cnt=%0d we=%b required 1 0 0",
                     ts_done, ts_event_count, bus.out_write_en);
        end
    endtask

    task automatic test_reset_mid_emit();
        int late = 0;
        // Sync clear: prime a non-zero count, then abort a 4-spike pixel after one write.
        send_pixel(8'd6, 8'd6, 4'b0011, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (ts_event_count !== CNTB'(2)) begin
            errors++;
            $display("FAIL rst_prime: cnt=%0d required 2", ts_event_count);
        end
        wq.delete();
        send_pixel(8'd6, 8'd6, 4'b1111, 1'b0);
        @(posedge clk); #1;
        sys_reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_write_en !== 1'b0) begin
            errors++;
            $display("FAIL sync_rst_gate: we=%b required 0", bus.out_write_en);
        end
        @(posedge clk); #1;
        sys_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_write_en !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || ts_event_count !== '0) begin
            errors++;
            $display("FAIL sync_rst_state: we=%b busy=%b ready=%b cnt=%0d required 0 0 1 0",
                     bus.out_write_en, busy, bus.in_ready, ts_event_count);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.out_write_en !== 1'b0) late++;
        end
        @(posedge clk); #1;
        checks++;
        if (late != 0 || wq.size() != 1) begin
            errors++;
            $display("FAIL sync_rst_writes: late=%0d writes=%0d required 0 1", late, wq.size());
        end
        // Async reset mid-cycle.
        send_pixel(8'd6, 8'd6, 4'b0011, 1'b1);
        repeat (3) @(negedge clk);
        wq.delete();
        send_pixel(8'd9, 8'd9, 4'b1111, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_write_en !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || ts_event_count !== '0) begin
            errors++;
            $display("FAIL async_rst_state: we=%b busy=%b ready=%b cnt=%0d required 0 0 1 0",
                     bus.out_write_en, busy, bus.in_ready, ts_event_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (wq.size() != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_writes: writes=%0d busy=%b required 1 0", wq.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_backpressure();
        test_zero_vector();
        test_timestep();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
